pixel_mem_arbiter: RTL

PIXEL_MEM_ARBITER -- requirements
Module: pixel_mem_arbiter

---
 rtl/pixel_mem_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pixel_mem_arbiter.sv
// pixel_mem_arbiter
//   Shares a single-port framebuffer RAM between the display scan-out and
//   game-logic cell writes. Scan reads always win; writes wait in a 2-deep
//   FIFO and drain on any cycle the scan does not need the RAM.
//   Writes to cells outside the framebuffer are accepted, dropped and counted.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   pix_en            one-cycle pixel-rate strobe
//   x_c, y_c          current scan column / row in screen pixels
//   wr_valid/ready    write request handshake
//   wr_x, wr_y        target cell column / row
//   wr_data           cell value to write
//   mem_addr/we/wdata RAM address, write strobe, write data (combinational)
//   mem_rdata         RAM read data, one cycle after the address
//   pix_data          pixel value to the display (registered)
//   pix_valid         one-cycle strobe, two cycles after each pix_en
//   err_cnt           saturating count of discarded out-of-range writes

module pixel_mem_arbiter #(
    parameter int unsigned FB_W  = 160,
    parameter int unsigned FB_H  = 120,
    parameter int unsigned SHIFT = 2,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    input  logic [15:0]   x_c,
    input  logic [15:0]   y_c,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [7:0]    wr_x,
    input  logic [6:0]    wr_y,
    input  logic [DW-1:0] wr_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] pix_data,
    output logic          pix_valid,
    output logic [7:0]    err_cnt
);

    // Visible screen area in screen pixels
    localparam int unsigned ACT_W = FB_W << SHIFT;
    localparam int unsigned ACT_H = FB_H << SHIFT;
    localparam int unsigned CW    = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          ok;
    } entry_t;

    // Registered state
    entry_t        fifo_q [2];
    logic          rd_ptr_q;
    logic          wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [AW-1:0] addr_q;
    logic          cap_valid_q;
    logic          cap_scan_q;

    // Combinational decisions
    logic          scan_slot;
    logic          push;
    logic          pop;
    entry_t        head;
    entry_t        new_entry;
    logic [CW-1:0] count_nxt;
    logic [7:0]    err_nxt;

    // Slot decision, FIFO control and RAM port drive
    always_comb begin
        scan_slot = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        head      = fifo_q[rd_ptr_q];
        new_entry = '0;
        count_nxt = count_q;
        err_nxt   = err_cnt;
        wr_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_addr  = addr_q;

        scan_slot = pix_en && (32'(x_c) < ACT_W) && (32'(y_c) < ACT_H);

        // Readiness looks only at the current count, so a full FIFO never
        // accepts even when it is draining this cycle.
        wr_ready  = !rst && (count_q < CW'(2));
        push      = wr_valid && wr_ready;
        pop       = !rst && !scan_slot && (count_q != '0);

        new_entry.addr = AW'(32'(wr_y) * FB_W + 32'(wr_x));
        new_entry.data = wr_data;
        new_entry.ok   = (32'(wr_x) < FB_W) && (32'(wr_y) < FB_H);

        count_nxt = count_q + CW'(push) - CW'(pop);

        if (pop && !head.ok && (err_cnt != 8'hFF)) begin
            err_nxt = err_cnt + 8'd1;
        end

        // Out-of-range pops and idle cycles leave the address where it was
        if (rst) begin
            mem_addr = '0;
        end else if (scan_slot) begin
            mem_addr = AW'(32'(y_c >> SHIFT) * FB_W + 32'(x_c >> SHIFT));
        end else if (pop && head.ok) begin
            mem_we    = 1'b1;
            mem_addr  = head.addr;
            mem_wdata = head.data;
        end
    end

    // FIFO, address hold and error counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
            addr_q   <= '0;
            err_cnt  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= new_entry;
                wr_ptr_q         <= !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            count_q <= count_nxt;
            addr_q  <= mem_addr;
            err_cnt <= err_nxt;
        end
    end

    // Pixel pipeline: remember the slot type for one cycle, then capture
    // the RAM data (or zero for blanking) as the read data arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_valid_q <= 1'b0;
            cap_scan_q  <= 1'b0;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
        end else begin
            cap_valid_q <= pix_en;
            cap_scan_q  <= scan_slot;
            pix_valid   <= cap_valid_q;
            if (cap_valid_q) begin
                pix_data <= cap_scan_q ? mem_rdata : '0;
            end
        end
    end

endmodule
